// File: rtl/lc3b_types.sv
// Shared cache geometry and types for the LC-3b 2-way set-associative cache.
package lc3b_types;
  localparam int C_NUM_SETS = 8;
  localparam int C_NUM_WAYS = 2;

  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [2:0]   lc3b_c_word_sel;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_FILL
  } cache_state_e;
endpackage

// File: rtl/lc3b_cache_if.sv
// CPU-side word bus and line-wide physical memory bus of the LC-3b cache.
interface lc3b_cache_if;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  // master is the environment (CPU plus physical memory), slave is the cache
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_control.sv
// IDLE/WRITEBACK/FILL sequencer: owns the CPU response and the physical
// memory handshake, and emits one-cycle strobes for the array updates.
module cache_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic hit,
  input  logic need_wb,
  input  logic pmem_resp,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic miss_start,
  output logic wb_done,
  output logic fill_done
);
  cache_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    miss_start = 1'b0;
    wb_done    = 1'b0;
    fill_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_d    = need_wb ? ST_WRITEBACK : ST_FILL;
          end
        end
      end
      ST_WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          wb_done = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: rtl/lc3b_cache.sv
// 2-way set-associative write-back cache for the LC-3b datapath (8 sets, 16B lines).
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module lc3b_cache
  import lc3b_types::*;
(
  input logic         clk,
  input logic         rst_n,
  lc3b_cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  lc3b_c_tag      cur_tag;
  lc3b_c_index    cur_index;
  lc3b_c_word_sel cur_word;
  logic           req, is_write, unused_addr_bit;

  assign cur_tag         = bus.mem_address[15:7];
  assign cur_index       = bus.mem_address[6:4];
  assign cur_word        = bus.mem_address[3:1];
  assign unused_addr_bit = bus.mem_address[0];
  assign req             = bus.mem_read | bus.mem_write;
  assign is_write        = bus.mem_write;

  logic [C_NUM_WAYS-1:0][C_NUM_SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [C_NUM_SETS-1:0] lru_q, lru_d;
  // Miss target is captured so the transaction survives the CPU dropping its request
  lc3b_c_tag   miss_tag_q, miss_tag_d;
  lc3b_c_index miss_index_q, miss_index_d;
  logic        victim_q, victim_d;

  logic       mem_resp, miss_start, wb_done, fill_done, hit, hit_sel, victim_sel, need_wb;
  logic       hit_write;
  logic [C_NUM_WAYS-1:0] hit_way, data_we;
  lc3b_c_line cur_line [C_NUM_WAYS];
  lc3b_c_line miss_line [C_NUM_WAYS];
  lc3b_c_tag  miss_way_tag [C_NUM_WAYS];
  lc3b_c_line hit_line, merged_line, wr_line;
  lc3b_c_index wr_index;

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_WAYS; gi++) begin : g_way
      localparam logic WAY = 1'(gi);
      lc3b_c_line data_mem [C_NUM_SETS];
      lc3b_c_tag  tag_mem  [C_NUM_SETS];

      always_ff @(posedge clk) begin
        if (data_we[gi]) data_mem[wr_index] <= wr_line;
        if (fill_done && victim_q == WAY) tag_mem[miss_index_q] <= miss_tag_q;
      end

      assign cur_line[gi]     = data_mem[cur_index];
      assign miss_line[gi]    = data_mem[miss_index_q];
      assign miss_way_tag[gi] = tag_mem[miss_index_q];
      assign hit_way[gi]      = valid_q[gi][cur_index] && (tag_mem[cur_index] == cur_tag);
      assign data_we[gi]      = (fill_done && victim_q == WAY) || (hit_write && hit_sel == WAY);
    end
  endgenerate

  assign hit        = |hit_way;
  assign hit_sel    = hit_way[1];
  assign hit_write  = mem_resp && is_write;
  assign victim_sel = !valid_q[0][cur_index] ? 1'b0 :
                      !valid_q[1][cur_index] ? 1'b1 : lru_q[cur_index];
  assign need_wb    = valid_q[victim_sel][cur_index] && dirty_q[victim_sel][cur_index];

  cache_control u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .hit        (hit),
    .need_wb    (need_wb),
    .pmem_resp  (bus.pmem_resp),
    .mem_resp   (mem_resp),
    .pmem_read  (bus.pmem_read),
    .pmem_write (bus.pmem_write),
    .miss_start (miss_start),
    .wb_done    (wb_done),
    .fill_done  (fill_done)
  );

  always_comb begin
    hit_line    = hit_sel ? cur_line[1] : cur_line[0];
    merged_line = hit_line;
    if (bus.mem_byte_enable[0]) merged_line[{cur_word, 4'b0000} +: 8] = bus.mem_wdata[7:0];
    if (bus.mem_byte_enable[1]) merged_line[{cur_word, 4'b1000} +: 8] = bus.mem_wdata[15:8];
    wr_line  = fill_done ? bus.pmem_rdata : merged_line;
    wr_index = fill_done ? miss_index_q : cur_index;
  end

  assign bus.mem_resp  = mem_resp;
  assign bus.mem_rdata = (mem_resp && !is_write) ? hit_line[{cur_word, 4'b0000} +: 16] : 16'h0000;

  always_comb begin
    bus.pmem_address = 16'h0000;
    bus.pmem_wdata   = '0;
    if (bus.pmem_write) begin
      bus.pmem_address = {miss_way_tag[victim_q], miss_index_q, 4'b0000};
      bus.pmem_wdata   = miss_line[victim_q];
    end else if (bus.pmem_read) begin
      bus.pmem_address = {miss_tag_q, miss_index_q, 4'b0000};
    end
  end

  always_comb begin
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    lru_d        = lru_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    victim_d     = victim_q;
    if (mem_resp) begin
      lru_d[cur_index] = ~hit_sel;
      if (is_write) dirty_d[hit_sel][cur_index] = 1'b1;
    end
    if (miss_start) begin
      miss_tag_d   = cur_tag;
      miss_index_d = cur_index;
      victim_d     = victim_sel;
    end
    if (wb_done) dirty_d[victim_q][miss_index_q] = 1'b0;
    if (fill_done) begin
      valid_d[victim_q][miss_index_q] = 1'b1;
      dirty_d[victim_q][miss_index_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
      victim_q     <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      lru_q        <= lru_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
      victim_q     <= victim_d;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (mem_resp && hit_count_q != 16'hFFFF)     hit_count_d  = hit_count_q + 16'd1;
    if (miss_start && miss_count_q != 16'hFFFF)  miss_count_d = miss_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_lc3b_cache.sv
// Directed bench for lc3b_cache: vector table of CPU accesses against a
// line-memory responder whose untouched lines hold word value == byte address.
module tb_lc3b_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc3b_cache_if bus();
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  lc3b_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    bit          exp_miss;
    bit          exp_wb;
    logic [15:0] exp_wb_addr;
    logic [15:0] exp_fill_addr;
    bit          chk_rdata;
    logic [15:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int passes = 0;
  int wb_seen = 0;
  int fill_seen = 0;
  logic [15:0] last_wb_addr = 16'h0;
  logic [15:0] last_fill_addr = 16'h0;
  bit pmem_hold = 1'b0;
  logic [127:0] pmem_store [logic [15:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] init_line(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = a + 16'(2 * k);
    return l;
  endfunction

  // Physical memory: answers each transaction on its third held cycle
  initial begin : responder
    int cnt;
    cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read || bus.pmem_write) begin
        check("pmem_exclusive", 32'(bus.pmem_read && bus.pmem_write), 32'd0);
        check("pmem_addr_align", 32'(bus.pmem_address[3:0]), 32'd0);
        check("resp_during_miss", 32'(bus.mem_resp), 32'd0);
        cnt++;
        if (cnt >= 3 && !pmem_hold) begin
          cnt = 0;
          bus.pmem_resp = 1'b1;
          if (bus.pmem_write) begin
            pmem_store[bus.pmem_address] = bus.pmem_wdata;
            wb_seen++;
            last_wb_addr = bus.pmem_address;
          end else begin
            bus.pmem_rdata = pmem_store.exists(bus.pmem_address) ?
                             pmem_store[bus.pmem_address] : init_line(bus.pmem_address);
            fill_seen++;
            last_fill_addr = bus.pmem_address;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int wb0, fill0, cyc, exp_cyc;
    bit got;
    logic [15:0] rdata;
    wb0 = wb_seen;
    fill0 = fill_seen;
    bus.mem_read        = v.rd;
    bus.mem_write       = v.wr;
    bus.mem_address     = v.addr;
    bus.mem_wdata       = v.wdata;
    bus.mem_byte_enable = v.be;
    got = 1'b0;
    cyc = 0;
    rdata = 16'h0;
    while (!got && cyc < 60) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        got = 1'b1;
        rdata = bus.mem_rdata;
      end else cyc++;
    end
    exp_cyc = v.exp_miss ? (v.exp_wb ? 7 : 4) : 0;
    check($sformatf("v%0d_resp_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(exp_cyc));
    check($sformatf("v%0d_wb_count", idx), 32'(wb_seen - wb0), 32'(v.exp_wb));
    check($sformatf("v%0d_fill_count", idx), 32'(fill_seen - fill0), 32'(v.exp_miss));
    if (v.exp_wb)    check($sformatf("v%0d_wb_addr", idx), 32'(last_wb_addr), 32'(v.exp_wb_addr));
    if (v.exp_miss)  check($sformatf("v%0d_fill_addr", idx), 32'(last_fill_addr), 32'(v.exp_fill_addr));
    if (v.chk_rdata) check($sformatf("v%0d_rdata", idx), 32'(rdata), 32'(v.exp_rdata));
    $display("vec %0d rd=%0b wr=%0b addr=%h be=%b wdata=%h -> cycles=%0d rdata=%h wb=%0d fill=%0d",
             idx, v.rd, v.wr, v.addr, v.be, v.wdata, cyc, rdata, wb_seen - wb0, fill_seen - fill0);
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic reset_mid_fill();
    bit got;
    pmem_hold = 1'b1;
    bus.mem_read    = 1'b1;
    bus.mem_address = 16'h0050;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.pmem_read) got = 1'b1;
    end
    check("rst_fill_started", 32'(got), 32'd1);
    check("rst_fill_addr", 32'(bus.pmem_address), 32'h0050);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_pmem_read", 32'(bus.pmem_read), 32'd0);
    check("rst_pmem_addr", 32'(bus.pmem_address), 32'd0);
    check("rst_mem_resp", 32'(bus.mem_resp), 32'd0);
    $display("reset asserted during FILL: pmem_read=%0b pmem_address=%h", bus.pmem_read, bus.pmem_address);
    bus.mem_read = 1'b0;
    pmem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam int NVEC = 22;
  localparam int RESET_AT = 20;
  vec_t vecs [NVEC];

  initial begin
    //           rd    wr    addr      wdata     be     miss  wb    wb_addr   fill_addr chk   rdata
    vecs[0]  = '{1'b1, 1'b0, 16'h0042, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0040, 1'b1, 16'h0042};
    vecs[1]  = '{1'b0, 1'b1, 16'h0042, 16'hBEEF, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0042, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00EF};
    vecs[3]  = '{1'b1, 1'b0, 16'h0840, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0840, 1'b1, 16'h0840};
    vecs[4]  = '{1'b0, 1'b1, 16'h0844, 16'h1234, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0040};
    vecs[6]  = '{1'b1, 1'b0, 16'h1040, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h0840, 16'h1040, 1'b1, 16'h1040};
    vecs[7]  = '{1'b1, 1'b0, 16'h0042, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h00EF};
    vecs[8]  = '{1'b1, 1'b0, 16'h0844, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0840, 1'b1, 16'h1234};
    vecs[9]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0020, 1'b1, 16'h0020};
    vecs[10] = '{1'b1, 1'b0, 16'h0420, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0420, 1'b1, 16'h0420};
    vecs[11] = '{1'b1, 1'b0, 16'h0820, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0820, 1'b1, 16'h0820};
    vecs[12] = '{1'b0, 1'b1, 16'h0822, 16'hFFFF, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 16'h0822, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0822};
    vecs[14] = '{1'b1, 1'b0, 16'h0C20, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0C20, 1'b1, 16'h0C20};
    vecs[15] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 1'b1, 1'b1, 16'h0820, 16'h0020, 1'b1, 16'h0020};
    vecs[16] = '{1'b0, 1'b1, 16'h0104, 16'hA5A5, 2'b10, 1'b1, 1'b0, 16'h0000, 16'h0100, 1'b0, 16'h0000};
    vecs[17] = '{1'b1, 1'b0, 16'h0104, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA504};
    vecs[18] = '{1'b1, 1'b1, 16'h0106, 16'h7777, 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
    vecs[19] = '{1'b1, 1'b0, 16'h0106, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h7777};
    // after a reset abandons a fill, every line misses and unwritten-back data is gone
    vecs[20] = '{1'b1, 1'b0, 16'h0050, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0050, 1'b1, 16'h0050};
    vecs[21] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 16'h0040, 1'b1, 16'h0042};

    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b00;
    bus.mem_address     = 16'h0000;
    bus.mem_wdata       = 16'h0000;
    #2;
    check("reset_mem_resp", 32'(bus.mem_resp), 32'd0);
    check("reset_mem_rdata", 32'(bus.mem_rdata), 32'd0);
    check("reset_pmem_read", 32'(bus.pmem_read), 32'd0);
    check("reset_pmem_write", 32'(bus.pmem_write), 32'd0);
    check("reset_pmem_address", 32'(bus.pmem_address), 32'd0);
`ifdef CACHE_STATS_EN
    check("reset_hit_count", 32'(hit_count), 32'd0);
    check("reset_miss_count", 32'(miss_count), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      if (i == RESET_AT) reset_mid_fill();
      run_vec(vecs[i], i);
`ifdef CACHE_STATS_EN
      if (i == 2) begin
        check("stats_miss_count", 32'(miss_count), 32'd1);
        check("stats_hit_count", 32'(hit_count), 32'd3);
      end
`endif
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/lc3b_cache.md
Name: lc3b_cache

Overview:
- 2-way set-associative, write-back, write-allocate cache between the LC-3b multi-cycle datapath (mem_address/mem_wdata/mem_rdata) and physical memory.
- Serves 16-bit word/byte accesses from line storage. Misses go to a 128-bit line-wide physical memory port with a request/response handshake.
- Contains 8 sets × 2 ways × 16-byte lines, with 1-bit LRU per set.

Parameters:
- none. Geometry is fixed by package constants.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  2  write byte lanes: [1]=high byte, [0]=low byte
- mem_address  in  16  CPU byte address
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  CPU read data
- mem_resp  out  1  CPU access complete, one cycle
- pmem_read  out  1  line fill request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  16  line address, bits [3:0] always 0
- pmem_wdata  out  128  victim line data
- pmem_rdata  in  128  fill line data
- pmem_resp  in  1  physical transaction complete, one cycle

Behaviour:
- Address split:
  - tag = addr[15:7] (9b)
  - index = addr[6:4]
  - word = addr[3:1]
  - addr[0] is ignored; byte lanes come from mem_byte_enable.
- State per way/set: valid, dirty, tag, 128b data. Per set: lru, which names the least-recently-used way.
- Reset (async, rst_n=0):
  - valid, dirty and lru all cleared; FSM goes to IDLE.
  - mem_resp, pmem_read and pmem_write = 0 immediately. mem_rdata and pmem_address = 0.
  - Data and tag arrays are not reset.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, hit (request active, a valid way's tag matches):
  - mem_resp=1 combinationally in the same cycle.
  - Read: mem_rdata = selected word of the hit way, same cycle.
  - Write: enabled bytes are merged into the word at the clock edge; that way's dirty is set.
  - lru := other way at the edge.
  - Hit latency is 0 extra cycles.
- IDLE, miss (request active, no hit):
  - Victim = way 0 if invalid, else way 1 if invalid, else way[lru].
  - Victim valid and dirty → WRITEBACK; otherwise → FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 4'b0}, pmem_wdata=victim data.
  - On pmem_resp → FILL, and the victim's dirty is cleared.
- FILL:
  - pmem_read=1, pmem_address={req tag, index, 4'b0}.
  - On pmem_resp edge: victim data := pmem_rdata, tag := req tag, valid=1, dirty=0; → IDLE.
  - The access then hits on the next cycle. Miss latency = writeback + fill handshakes + 1 cycle.
- mem_read and mem_write both high: treated as a write.
- Request dropped mid-miss: the current pmem transaction completes and the line is installed; no mem_resp is issued.
- pmem_read and pmem_write are never both high. Both stay held, with stable address and data, until pmem_resp.
- mem_resp is never asserted outside IDLE.
- Reset mid-miss: the transaction is abandoned and the victim's state is left as it was before the miss. Exception: if WRITEBACK already completed, that victim's dirty is already clear.
- Byte write with mem_byte_enable=2'b00: hit response, no data change, but dirty is still set.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined, adds outputs hit_count[15:0] and miss_count[15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - hit_count increments on every hit edge, including the post-fill hit.
  - miss_count increments once per IDLE→miss decision.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Add to lc3b_types:
  - typedefs lc3b_c_tag (9b), lc3b_c_index (3b), lc3b_c_word_sel (3b), lc3b_c_line (128b)
  - constants for set count (8) and way count (2)
- Sub-module cache_control holds the IDLE/WRITEBACK/FILL FSM and handshake outputs.
- Tag/valid/dirty/lru/data arrays, compare, and byte merge stay in lc3b_cache.

Test Plan:
- Cold read 0x0042 → FILL with pmem_address=0x0040. After pmem_resp, mem_resp next cycle with mem_rdata = bytes 2–3 of the fill line. No WRITEBACK.
- Write 0xBEEF, byte_enable=2'b01, to 0x0042 after the fill → same-cycle mem_resp, and a reread returns low byte 0xEF with the high byte unchanged.
- Fill both ways of index 4 (0x0040, 0x0840), dirty both, touch 0x0040, then read 0x1040:
  - WRITEBACK of way holding 0x0840 with pmem_address=0x0840, then FILL 0x1040.
  - 0x0040 still hits.
- Clean eviction: same set, no writes → no pmem_write, FILL only.
- Assert rst_n=0 during FILL → pmem_read drops immediately. After release, the same read misses again (line not installed).
- CACHE_STATS_EN build: for the cold-read/write/reread sequence above, miss_count=1 and hit_count=3.
